// File: rtl/w0rm_data_bus_arbiter.sv
// Two-port round-robin arbiter sharing one request/response data bus.
// Each port owns a single-entry request slot; one bus transaction is in flight at a time.
module w0rm_data_bus_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  p0_write_in,
    input  logic                  p0_read_in,
    input  logic                  p0_valid_in,
    input  logic [ADDR_WIDTH-1:0] p0_addr_in,
    input  logic [DATA_WIDTH-1:0] p0_data_in,
    output logic [DATA_WIDTH-1:0] p0_data_out,
    output logic                  p0_valid_out,
    output logic                  p0_error_out,
    output logic                  p0_busy_out,

    input  logic                  p1_write_in,
    input  logic                  p1_read_in,
    input  logic                  p1_valid_in,
    input  logic [ADDR_WIDTH-1:0] p1_addr_in,
    input  logic [DATA_WIDTH-1:0] p1_data_in,
    output logic [DATA_WIDTH-1:0] p1_data_out,
    output logic                  p1_valid_out,
    output logic                  p1_error_out,
    output logic                  p1_busy_out,

    output logic                  bus_write_out,
    output logic                  bus_read_out,
    output logic                  bus_valid_out,
    output logic [ADDR_WIDTH-1:0] bus_addr_out,
    output logic [DATA_WIDTH-1:0] bus_data_out,
    input  logic [DATA_WIDTH-1:0] bus_data_in,
    input  logic                  bus_valid_in
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);
    localparam bit          TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);

    state_e state_q, state_d;

    logic [1:0]            in_valid;
    logic [1:0]            in_write;
    logic [1:0]            in_read;
    logic [ADDR_WIDTH-1:0] in_addr [2];
    logic [DATA_WIDTH-1:0] in_data [2];

    logic [1:0]            slot_vld_q;
    logic [1:0]            slot_wr_q;
    logic [ADDR_WIDTH-1:0] slot_addr_q [2];
    logic [DATA_WIDTH-1:0] slot_data_q [2];

    logic                  gnt_q;
    logic                  last_grant_q;
    logic [15:0]           cnt_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] rsp_data_q [2];

    logic                  bus_write_q;
    logic                  bus_read_q;
    logic [ADDR_WIDTH-1:0] bus_addr_q;
    logic [DATA_WIDTH-1:0] bus_data_q;

    logic                  grant_fire;
    logic                  grant_port;
    logic                  in_flight;
    logic                  bus_done;
    logic                  timeout_hit;
    logic [16:0]           cnt_inc;
    logic                  bus_valid;
    logic [1:0]            responding;
    logic [1:0]            busy;
    logic [1:0]            capture;

    assign in_valid   = {p1_valid_in, p0_valid_in};
    assign in_write   = {p1_write_in, p0_write_in};
    assign in_read    = {p1_read_in,  p0_read_in};
    assign in_addr[0] = p0_addr_in;
    assign in_addr[1] = p1_addr_in;
    assign in_data[0] = p0_data_in;
    assign in_data[1] = p1_data_in;

    // A slot frees up combinationally in its response cycle so the requester can refill it at once.
    assign busy    = slot_vld_q & ~responding;
    assign capture = in_valid & (in_write | in_read) & ~busy;

    assign in_flight   = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign bus_done    = in_flight && bus_valid_in;
    assign cnt_inc     = {1'b0, cnt_q} + 17'd1;
    assign timeout_hit = TIMEOUT_EN && in_flight && !bus_valid_in
                         && (cnt_inc >= {1'b0, TIMEOUT_LIM});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_fire = 1'b0;
        grant_port = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|slot_vld_q) begin
                    grant_fire = 1'b1;
                    grant_port = (&slot_vld_q) ? ~last_grant_q : slot_vld_q[1];
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE, ST_WAIT: begin
                if (bus_done || timeout_hit) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        bus_valid  = 1'b0;
        responding = 2'b00;
        case (state_q)
            ST_ISSUE: bus_valid = 1'b1;
            ST_RESP:  responding[gnt_q] = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_vld_q    <= 2'b00;
            slot_wr_q     <= 2'b00;
            gnt_q         <= 1'b0;
            last_grant_q  <= 1'b1;
            cnt_q         <= 16'd0;
            err_q         <= 1'b0;
            bus_write_q   <= 1'b0;
            bus_read_q    <= 1'b0;
            bus_addr_q    <= '0;
            bus_data_q    <= '0;
            rsp_data_q[0] <= '0;
            rsp_data_q[1] <= '0;
        end else begin
            // Capture wins over the response-cycle clear so a refill is never lost.
            for (int n = 0; n < 2; n++) begin
                if (capture[n]) begin
                    slot_vld_q[n] <= 1'b1;
                    slot_wr_q[n]  <= in_write[n];
                end else if (responding[n]) begin
                    slot_vld_q[n] <= 1'b0;
                end
            end

            if (grant_fire) begin
                gnt_q        <= grant_port;
                last_grant_q <= grant_port;
                cnt_q        <= 16'd0;
                bus_write_q  <= slot_wr_q[grant_port];
                bus_read_q   <= ~slot_wr_q[grant_port];
                bus_addr_q   <= slot_addr_q[grant_port];
                bus_data_q   <= slot_wr_q[grant_port] ? slot_data_q[grant_port] : '0;
            end else if (state_q == ST_RESP) begin
                err_q       <= 1'b0;
                bus_write_q <= 1'b0;
                bus_read_q  <= 1'b0;
                bus_addr_q  <= '0;
                bus_data_q  <= '0;
            end else if (bus_done) begin
                err_q             <= 1'b0;
                rsp_data_q[gnt_q] <= bus_read_q ? bus_data_in : '0;
            end else if (timeout_hit) begin
                err_q             <= 1'b1;
                rsp_data_q[gnt_q] <= '0;
            end else if (in_flight && (cnt_q != 16'hFFFF)) begin
                cnt_q <= cnt_inc[15:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            if (capture[n]) begin
                slot_addr_q[n] <= in_addr[n];
                slot_data_q[n] <= in_data[n];
            end
        end
    end

    assign p0_data_out  = rsp_data_q[0];
    assign p0_valid_out = responding[0];
    assign p0_error_out = responding[0] & err_q;
    assign p0_busy_out  = busy[0];

    assign p1_data_out  = rsp_data_q[1];
    assign p1_valid_out = responding[1];
    assign p1_error_out = responding[1] & err_q;
    assign p1_busy_out  = busy[1];

    assign bus_write_out = bus_write_q;
    assign bus_read_out  = bus_read_q;
    assign bus_valid_out = bus_valid;
    assign bus_addr_out  = bus_addr_q;
    assign bus_data_out  = bus_data_q;

endmodule

// File: tb/tb_w0rm_data_bus_arbiter.sv
// Directed bench for w0rm_data_bus_arbiter: latency, round-robin, busy, timeout and reset.
module tb_w0rm_data_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          p0_write_in, p0_read_in, p0_valid_in;
    logic [AW-1:0] p0_addr_in;
    logic [DW-1:0] p0_data_in;
    logic [DW-1:0] p0_data_out;
    logic          p0_valid_out, p0_error_out, p0_busy_out;
    logic          p1_write_in, p1_read_in, p1_valid_in;
    logic [AW-1:0] p1_addr_in;
    logic [DW-1:0] p1_data_in;
    logic [DW-1:0] p1_data_out;
    logic          p1_valid_out, p1_error_out, p1_busy_out;
    logic          bus_write_out, bus_read_out, bus_valid_out;
    logic [AW-1:0] bus_addr_out;
    logic [DW-1:0] bus_data_out;
    logic [DW-1:0] bus_data_in;
    logic          bus_valid_in;

    int checks   = 0;
    int failures = 0;

    w0rm_data_bus_arbiter #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .p0_write_in  (p0_write_in),
        .p0_read_in   (p0_read_in),
        .p0_valid_in  (p0_valid_in),
        .p0_addr_in   (p0_addr_in),
        .p0_data_in   (p0_data_in),
        .p0_data_out  (p0_data_out),
        .p0_valid_out (p0_valid_out),
        .p0_error_out (p0_error_out),
        .p0_busy_out  (p0_busy_out),
        .p1_write_in  (p1_write_in),
        .p1_read_in   (p1_read_in),
        .p1_valid_in  (p1_valid_in),
        .p1_addr_in   (p1_addr_in),
        .p1_data_in   (p1_data_in),
        .p1_data_out  (p1_data_out),
        .p1_valid_out (p1_valid_out),
        .p1_error_out (p1_error_out),
        .p1_busy_out  (p1_busy_out),
        .bus_write_out(bus_write_out),
        .bus_read_out (bus_read_out),
        .bus_valid_out(bus_valid_out),
        .bus_addr_out (bus_addr_out),
        .bus_data_out (bus_data_out),
        .bus_data_in  (bus_data_in),
        .bus_valid_in (bus_valid_in)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_p0_valid"}, {63'd0, p0_valid_out}, 64'd0);
        chk({tag, "_p1_valid"}, {63'd0, p1_valid_out}, 64'd0);
        chk({tag, "_p0_error"}, {63'd0, p0_error_out}, 64'd0);
        chk({tag, "_p1_error"}, {63'd0, p1_error_out}, 64'd0);
        chk({tag, "_p0_busy"},  {63'd0, p0_busy_out},  64'd0);
        chk({tag, "_p1_busy"},  {63'd0, p1_busy_out},  64'd0);
        chk({tag, "_bus_valid"}, {63'd0, bus_valid_out}, 64'd0);
        chk({tag, "_bus_write"}, {63'd0, bus_write_out}, 64'd0);
        chk({tag, "_bus_read"},  {63'd0, bus_read_out},  64'd0);
        chk({tag, "_bus_addr"},  {32'd0, bus_addr_out},  64'd0);
        chk({tag, "_bus_data"},  {32'd0, bus_data_out},  64'd0);
    endtask

    initial begin
        reset_n     = 1'b0;
        p0_write_in = 1'b0; p0_read_in = 1'b0; p0_valid_in = 1'b0;
        p0_addr_in  = '0;   p0_data_in = '0;
        p1_write_in = 1'b0; p1_read_in = 1'b0; p1_valid_in = 1'b0;
        p1_addr_in  = '0;   p1_data_in = '0;
        bus_data_in = '0;   bus_valid_in = 1'b0;

        // Reset state
        tick(); tick();
        chk_quiet("reset");
        chk("reset_p0_data", {32'd0, p0_data_out}, 64'd0);
        chk("reset_p1_data", {32'd0, p1_data_out}, 64'd0);
        reset_n = 1'b1;
        tick();

        // Simultaneous requests after reset: p0 wins, then p1
        p0_read_in = 1'b1; p0_addr_in = 32'hA0; p0_valid_in = 1'b1;
        p1_read_in = 1'b1; p1_addr_in = 32'hB0; p1_valid_in = 1'b1;
        tick();
        p0_valid_in = 1'b0; p1_valid_in = 1'b0; p0_read_in = 1'b0; p1_read_in = 1'b0;
        chk("sim1_p0_busy", {63'd0, p0_busy_out}, 64'd1);
        chk("sim1_p1_busy", {63'd0, p1_busy_out}, 64'd1);
        tick();
        chk("sim1_first_valid", {63'd0, bus_valid_out}, 64'd1);
        chk("sim1_first_addr", {32'd0, bus_addr_out}, 64'hA0);
        bus_valid_in = 1'b1; bus_data_in = 32'h11;
        tick();
        bus_valid_in = 1'b0;
        chk("sim1_p0_resp", {63'd0, p0_valid_out}, 64'd1);
        chk("sim1_p0_data", {32'd0, p0_data_out}, 64'h11);
        chk("sim1_p1_still_busy", {63'd0, p1_busy_out}, 64'd1);
        tick();
        tick();
        chk("sim1_second_valid", {63'd0, bus_valid_out}, 64'd1);
        chk("sim1_second_addr", {32'd0, bus_addr_out}, 64'hB0);
        bus_valid_in = 1'b1; bus_data_in = 32'h22;
        tick();
        bus_valid_in = 1'b0;
        chk("sim1_p1_resp", {63'd0, p1_valid_out}, 64'd1);
        chk("sim1_p1_data", {32'd0, p1_data_out}, 64'h22);
        tick();

        // Single read, minimum latency
        p0_read_in = 1'b1; p0_addr_in = 32'h100; p0_valid_in = 1'b1;
        tick();
        p0_valid_in = 1'b0; p0_read_in = 1'b0;
        chk("rd_c1_busy", {63'd0, p0_busy_out}, 64'd1);
        chk("rd_c1_bus_valid", {63'd0, bus_valid_out}, 64'd0);
        tick();
        chk("rd_c2_bus_valid", {63'd0, bus_valid_out}, 64'd1);
        chk("rd_c2_bus_read", {63'd0, bus_read_out}, 64'd1);
        chk("rd_c2_bus_write", {63'd0, bus_write_out}, 64'd0);
        chk("rd_c2_bus_addr", {32'd0, bus_addr_out}, 64'h100);
        bus_valid_in = 1'b1; bus_data_in = 32'hDEADBEEF;
        tick();
        bus_valid_in = 1'b0; bus_data_in = '0;
        chk("rd_c3_p0_valid", {63'd0, p0_valid_out}, 64'd1);
        chk("rd_c3_p0_data", {32'd0, p0_data_out}, 64'hDEADBEEF);
        chk("rd_c3_p0_error", {63'd0, p0_error_out}, 64'd0);
        chk("rd_c3_p0_busy", {63'd0, p0_busy_out}, 64'd0);
        chk("rd_c3_bus_valid", {63'd0, bus_valid_out}, 64'd0);
        chk("rd_c3_p1_valid", {63'd0, p1_valid_out}, 64'd0);
        tick();
        chk("rd_c4_p0_valid", {63'd0, p0_valid_out}, 64'd0);
        chk("rd_c4_p0_hold", {32'd0, p0_data_out}, 64'hDEADBEEF);
        chk("rd_c4_bus_read_clr", {63'd0, bus_read_out}, 64'd0);
        chk("rd_c4_bus_addr_clr", {32'd0, bus_addr_out}, 64'd0);

        // Simultaneous again with p0 served last: p1 goes first
        p0_read_in = 1'b1; p0_addr_in = 32'hC0; p0_valid_in = 1'b1;
        p1_read_in = 1'b1; p1_addr_in = 32'hD0; p1_valid_in = 1'b1;
        tick();
        p0_valid_in = 1'b0; p1_valid_in = 1'b0; p0_read_in = 1'b0; p1_read_in = 1'b0;
        tick();
        chk("sim2_first_addr", {32'd0, bus_addr_out}, 64'hD0);
        bus_valid_in = 1'b1; bus_data_in = 32'h33;
        tick();
        bus_valid_in = 1'b0;
        chk("sim2_p1_resp", {63'd0, p1_valid_out}, 64'd1);
        chk("sim2_p0_no_resp", {63'd0, p0_valid_out}, 64'd0);
        tick();
        tick();
        chk("sim2_second_addr", {32'd0, bus_addr_out}, 64'hC0);
        bus_valid_in = 1'b1; bus_data_in = 32'h44;
        tick();
        bus_valid_in = 1'b0;
        chk("sim2_p0_resp", {63'd0, p0_valid_out}, 64'd1);
        chk("sim2_p0_data", {32'd0, p0_data_out}, 64'h44);
        tick();

        // Write with five wait cycles
        p1_write_in = 1'b1; p1_addr_in = 32'h20; p1_data_in = 32'h1234; p1_valid_in = 1'b1;
        tick();
        p1_valid_in = 1'b0; p1_write_in = 1'b0; p1_data_in = '0;
        tick();
        chk("wr_issue_valid", {63'd0, bus_valid_out}, 64'd1);
        chk("wr_issue_write", {63'd0, bus_write_out}, 64'd1);
        chk("wr_issue_read", {63'd0, bus_read_out}, 64'd0);
        chk("wr_issue_data", {32'd0, bus_data_out}, 64'h1234);
        chk("wr_issue_addr", {32'd0, bus_addr_out}, 64'h20);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("wr_wait_valid", {63'd0, bus_valid_out}, 64'd0);
            chk("wr_wait_write", {63'd0, bus_write_out}, 64'd1);
            chk("wr_wait_data", {32'd0, bus_data_out}, 64'h1234);
            chk("wr_wait_no_resp", {63'd0, p1_valid_out}, 64'd0);
        end
        bus_valid_in = 1'b1; bus_data_in = 32'hCAFE;
        tick();
        bus_valid_in = 1'b0; bus_data_in = '0;
        chk("wr_p1_valid", {63'd0, p1_valid_out}, 64'd1);
        chk("wr_p1_data_zero", {32'd0, p1_data_out}, 64'd0);
        chk("wr_p1_error", {63'd0, p1_error_out}, 64'd0);
        chk("wr_p0_untouched", {32'd0, p0_data_out}, 64'h44);
        tick();
        chk("wr_p1_single_pulse", {63'd0, p1_valid_out}, 64'd0);

        // Busy rules: ignored while busy, accepted in the response cycle
        p0_read_in = 1'b1; p0_addr_in = 32'h300; p0_valid_in = 1'b1;
        tick();
        p0_addr_in = 32'h304;
        chk("busy_c1_busy", {63'd0, p0_busy_out}, 64'd1);
        tick();
        p0_valid_in = 1'b0; p0_read_in = 1'b0;
        chk("busy_c2_issue", {63'd0, bus_valid_out}, 64'd1);
        chk("busy_c2_addr", {32'd0, bus_addr_out}, 64'h300);
        tick();
        bus_valid_in = 1'b1; bus_data_in = 32'h55;
        tick();
        bus_valid_in = 1'b0;
        chk("busy_resp_valid", {63'd0, p0_valid_out}, 64'd1);
        chk("busy_resp_data", {32'd0, p0_data_out}, 64'h55);
        chk("busy_resp_busy_low", {63'd0, p0_busy_out}, 64'd0);
        p0_read_in = 1'b1; p0_addr_in = 32'h308; p0_valid_in = 1'b1;
        tick();
        p0_valid_in = 1'b0; p0_read_in = 1'b0;
        chk("busy_refill_busy", {63'd0, p0_busy_out}, 64'd1);
        chk("busy_refill_idle", {63'd0, bus_valid_out}, 64'd0);
        tick();
        chk("busy_second_issue", {63'd0, bus_valid_out}, 64'd1);
        chk("busy_second_addr", {32'd0, bus_addr_out}, 64'h308);
        bus_valid_in = 1'b1; bus_data_in = 32'h66;
        tick();
        bus_valid_in = 1'b0;
        chk("busy_second_resp", {63'd0, p0_valid_out}, 64'd1);
        chk("busy_second_data", {32'd0, p0_data_out}, 64'h66);
        tick();
        tick();
        chk("busy_no_third", {63'd0, bus_valid_out}, 64'd0);
        chk("busy_no_pending", {63'd0, p0_busy_out}, 64'd0);

        // Timeout after 8 cycles counted from ISSUE, then a late bus_valid_in is ignored
        p0_read_in = 1'b1; p0_addr_in = 32'h400; p0_valid_in = 1'b1;
        tick();
        p0_valid_in = 1'b0; p0_read_in = 1'b0;
        tick();
        chk("to_issue", {63'd0, bus_valid_out}, 64'd1);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("to_wait_no_resp", {63'd0, p0_valid_out}, 64'd0);
            chk("to_wait_read", {63'd0, bus_read_out}, 64'd1);
        end
        tick();
        chk("to_p0_valid", {63'd0, p0_valid_out}, 64'd1);
        chk("to_p0_error", {63'd0, p0_error_out}, 64'd1);
        chk("to_p0_data", {32'd0, p0_data_out}, 64'd0);
        tick();
        chk("to_after_valid", {63'd0, p0_valid_out}, 64'd0);
        chk("to_after_error", {63'd0, p0_error_out}, 64'd0);
        bus_valid_in = 1'b1; bus_data_in = 32'h77;
        tick();
        bus_valid_in = 1'b0; bus_data_in = '0;
        chk("late_p0_valid", {63'd0, p0_valid_out}, 64'd0);
        chk("late_p1_valid", {63'd0, p1_valid_out}, 64'd0);
        chk("late_p0_data", {32'd0, p0_data_out}, 64'd0);
        tick();
        chk("late_p0_valid2", {63'd0, p0_valid_out}, 64'd0);
        chk("late_bus_valid", {63'd0, bus_valid_out}, 64'd0);

        // Reset mid-WAIT with p1 in flight and p0 pending
        p1_read_in = 1'b1; p1_addr_in = 32'h500; p1_valid_in = 1'b1;
        tick();
        p1_valid_in = 1'b0; p1_read_in = 1'b0;
        p0_read_in = 1'b1; p0_addr_in = 32'h600; p0_valid_in = 1'b1;
        tick();
        p0_valid_in = 1'b0; p0_read_in = 1'b0;
        chk("rst_issue_addr", {32'd0, bus_addr_out}, 64'h500);
        tick();
        chk("rst_wait_p0_pending", {63'd0, p0_busy_out}, 64'd1);
        reset_n = 1'b0;
        #1;
        chk_quiet("rst_async");
        chk("rst_async_p1_data", {32'd0, p1_data_out}, 64'd0);
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rst_rel_p0_valid", {63'd0, p0_valid_out}, 64'd0);
            chk("rst_rel_p1_valid", {63'd0, p1_valid_out}, 64'd0);
            chk("rst_rel_bus_valid", {63'd0, bus_valid_out}, 64'd0);
        end
        p1_read_in = 1'b1; p1_addr_in = 32'h504; p1_valid_in = 1'b1;
        tick();
        p1_valid_in = 1'b0; p1_read_in = 1'b0;
        tick();
        chk("fresh_issue", {63'd0, bus_valid_out}, 64'd1);
        chk("fresh_addr", {32'd0, bus_addr_out}, 64'h504);
        bus_valid_in = 1'b1; bus_data_in = 32'h99;
        tick();
        bus_valid_in = 1'b0;
        chk("fresh_p1_valid", {63'd0, p1_valid_out}, 64'd1);
        chk("fresh_p1_data", {32'd0, p1_data_out}, 64'h99);
        chk("fresh_p1_error", {63'd0, p1_error_out}, 64'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
